// File: rtl/axis_packet_arbiter.sv
// Round-robin, packet-granular AXI-Stream arbiter: merges NUM_S sources onto one
// registered master port, holding each grant until the granted source's tlast.
module axis_packet_arbiter #(
    parameter int NUM_S       = 4,
    parameter int TDATA_WIDTH = 32,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic [NUM_S-1:0]               en_mask,
    input  logic [NUM_S-1:0]               s_axis_tvalid,
    input  logic [NUM_S*TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [NUM_S-1:0]               s_axis_tlast,
    output logic [NUM_S-1:0]               s_axis_tready,
    output logic                           m_axis_tvalid,
    output logic [TDATA_WIDTH-1:0]         m_axis_tdata,
    output logic                           m_axis_tlast,
    output logic [$clog2(NUM_S)-1:0]       m_axis_tid,
    input  logic                           m_axis_tready,
    output logic                           busy,
    output logic [CNT_WIDTH-1:0]           pkt_count
);

    localparam int ID_W = $clog2(NUM_S);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PASS = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [ID_W-1:0]        grant_q, grant_d;
    logic [ID_W-1:0]        last_grant_q, last_grant_d;
    logic                   m_tvalid_q, m_tvalid_d;
    logic [TDATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
    logic                   m_tlast_q, m_tlast_d;
    logic [ID_W-1:0]        m_tid_q, m_tid_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [NUM_S-1:0]       s_ready_s;
    logic                   load_s;
    logic                   m_hs_s;
    logic [ID_W:0]          pick_s;

    // Returns {found, index}; the descending loop leaves the smallest upward offset from last.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_S-1:0] req,
                                              input logic [ID_W-1:0]  last);
        logic [ID_W:0] res;
        int            idx;
        res = '0;
        for (int off = NUM_S; off >= 1; off--) begin
            idx = (int'(last) + off) % NUM_S;
            if (req[idx]) begin
                res = {1'b1, ID_W'(idx)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Arbitration and packet-forwarding state machine.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        s_ready_s    = '0;
        load_s       = 1'b0;
        pick_s       = rr_pick(s_axis_tvalid & en_mask, last_grant_q);
        case (state_q)
            ST_IDLE: begin
                if (pick_s[ID_W]) begin
                    grant_d      = pick_s[ID_W-1:0];
                    last_grant_d = pick_s[ID_W-1:0];
                    state_d      = ST_PASS;
                end else begin
                    state_d      = ST_IDLE;
                end
            end
            ST_PASS: begin
                s_ready_s[grant_q] = !m_tvalid_q || m_axis_tready;
                load_s             = s_axis_tvalid[grant_q] && s_ready_s[grant_q];
                if (load_s && s_axis_tlast[grant_q]) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_PASS;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign m_hs_s = m_tvalid_q && m_axis_tready;

    // Output register: a load wins over an unload so back-to-back beats keep tvalid high.
    always_comb begin
        m_tvalid_d = m_tvalid_q;
        m_tdata_d  = m_tdata_q;
        m_tlast_d  = m_tlast_q;
        m_tid_d    = m_tid_q;
        if (load_s) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = s_axis_tdata[int'(grant_q)*TDATA_WIDTH +: TDATA_WIDTH];
            m_tlast_d  = s_axis_tlast[grant_q];
            m_tid_d    = grant_q;
        end else if (m_hs_s) begin
            m_tvalid_d = 1'b0;
        end else begin
            m_tvalid_d = m_tvalid_q;
        end
    end

    // Packet counter wraps naturally at 2^CNT_WIDTH.
    always_comb begin
        if (m_hs_s && m_tlast_q) begin
            cnt_d = cnt_q + CNT_WIDTH'(1'b1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State and output registers; last_grant resets to NUM_S-1 so source 0 is searched first.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= ID_W'(NUM_S - 1);
            m_tvalid_q   <= 1'b0;
            m_tdata_q    <= '0;
            m_tlast_q    <= 1'b0;
            m_tid_q      <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            m_tvalid_q   <= m_tvalid_d;
            m_tdata_q    <= m_tdata_d;
            m_tlast_q    <= m_tlast_d;
            m_tid_q      <= m_tid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign s_axis_tready = s_ready_s;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tlast  = m_tlast_q;
    assign m_axis_tid    = m_tid_q;
    assign busy          = (state_q == ST_PASS) || m_tvalid_q;
    assign pkt_count     = cnt_q;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed bench for axis_packet_arbiter: arbitration vector table plus
// multi-cycle sequences driven by a small source model and a per-tid scoreboard.
module tb_axis_packet_arbiter;

    localparam int NS = 4;
    localparam int DW = 32;
    localparam int CW = 4;
    localparam int IW = 2;

    logic              aclk;
    logic              areset;
    logic [NS-1:0]     en_mask;
    logic [NS-1:0]     s_axis_tvalid;
    logic [NS*DW-1:0]  s_axis_tdata;
    logic [NS-1:0]     s_axis_tlast;
    logic [NS-1:0]     s_axis_tready;
    logic              m_axis_tvalid;
    logic [DW-1:0]     m_axis_tdata;
    logic              m_axis_tlast;
    logic [IW-1:0]     m_axis_tid;
    logic              m_axis_tready;
    logic              busy;
    logic [CW-1:0]     pkt_count;

    axis_packet_arbiter #(.NUM_S(NS), .TDATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .aclk(aclk), .areset(areset), .en_mask(en_mask),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
        .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
        .m_axis_tready(m_axis_tready), .busy(busy), .pkt_count(pkt_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [3:0] en;
        logic [3:0] vld;
        int         exp_tid;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [3:0] src_act;
    int  src_beat [NS];
    int  src_pkt  [NS];
    int  src_len  [NS];
    int  src_pause[NS];
    int  cap_beat [NS];
    int  exp_beat [NS];
    int  exp_pkt  [NS];
    bit  oneshot_all, rand_ready, stall_en, open;
    int  open_tid, nolast_cnt, pause_cycles;
    int  pkt_q[$];
    bit  tv_hist[$];

    logic [3:0]  cap_s_hs, cap_s_ready, cap_s_first;
    logic        cap_m_hs, cap_m_last, cap_m_tvalid;
    logic [31:0] cap_m_data;
    logic [1:0]  cap_m_tid;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive_sources();
        for (int i = 0; i < NS; i++) begin
            s_axis_tvalid[i]         = src_act[i] && (src_pause[i] == 0);
            s_axis_tdata[i*DW +: DW] = {8'(i), 8'(src_pkt[i]), 16'(src_beat[i])};
            s_axis_tlast[i]          = (src_beat[i] == src_len[i] - 1);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            src_beat[i] = 0; src_pkt[i] = 0; src_pause[i] = 0; src_len[i] = 1;
            exp_beat[i] = 0; exp_pkt[i] = 0; cap_beat[i] = 0;
        end
        open = 0; open_tid = 0; nolast_cnt = 0; pause_cycles = 0;
        pkt_q.delete(); tv_hist.delete();
        src_act = 4'b0000; oneshot_all = 0; rand_ready = 0; stall_en = 0;
        en_mask = 4'b1111; m_axis_tready = 1'b1;
        drive_sources();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_s_tready"}, s_axis_tready, 4'b0000);
        chk({tag, "_m_tvalid"}, m_axis_tvalid, 1'b0);
        chk({tag, "_m_tdata"},  m_axis_tdata, 32'h0);
        chk({tag, "_m_tlast"},  m_axis_tlast, 1'b0);
        chk({tag, "_m_tid"},    m_axis_tid, 2'd0);
        chk({tag, "_pkt_count"}, pkt_count, 4'd0);
        chk({tag, "_busy"},     busy, 1'b0);
    endtask

    task automatic do_reset();
        areset = 1'b1;
        model_reset();
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
    endtask

    // One clock: capture at negedge, then scoreboard and source update after the edge.
    task automatic step();
        int t;
        @(negedge aclk);
        cap_s_ready  = s_axis_tready;
        cap_s_hs     = s_axis_tvalid & s_axis_tready;
        cap_m_tvalid = m_axis_tvalid;
        cap_m_hs     = m_axis_tvalid & m_axis_tready;
        cap_m_data   = m_axis_tdata;
        cap_m_last   = m_axis_tlast;
        cap_m_tid    = m_axis_tid;
        @(posedge aclk);
        #1;
        tv_hist.push_back(cap_m_tvalid);
        if (cap_m_hs) begin
            t = int'(cap_m_tid);
            if (!cap_m_last) nolast_cnt++;
            if (open) chk("no_interleave", t, open_tid);
            chk("beat_data", cap_m_data, {8'(t), 8'(exp_pkt[t]), 16'(exp_beat[t])});
            chk("beat_tlast", cap_m_last, (exp_beat[t] == src_len[t] - 1));
            if (exp_beat[t] == src_len[t] - 1) begin
                exp_beat[t] = 0; exp_pkt[t]++; open = 0; pkt_q.push_back(t);
            end else begin
                exp_beat[t]++; open = 1; open_tid = t;
            end
        end
        for (int i = 0; i < NS; i++) begin
            cap_beat[i]    = src_beat[i];
            cap_s_first[i] = cap_s_hs[i] && (src_beat[i] == 0);
            if (src_pause[i] > 0) src_pause[i]--;
            if (cap_s_hs[i]) begin
                if (stall_en && i == 1 && src_beat[i] == 2) src_pause[i] = 5;
                if (src_beat[i] == src_len[i] - 1) begin
                    src_beat[i] = 0; src_pkt[i]++;
                end else begin
                    src_beat[i]++;
                end
            end
            if (src_pause[i] > 0) pause_cycles++;
        end
        if (oneshot_all && (|cap_s_hs)) src_act = 4'b0000;
        m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        drive_sources();
    endtask

    vec_t vecs[12];

    initial begin
        int got, bad, f;
        bit masked, rdy_seen;

        vecs[0]  = '{4'b1111, 4'b1111, 0};
        vecs[1]  = '{4'b1111, 4'b1111, 1};
        vecs[2]  = '{4'b1111, 4'b1001, 3};
        vecs[3]  = '{4'b1111, 4'b0110, 1};
        vecs[4]  = '{4'b0101, 4'b1111, 2};
        vecs[5]  = '{4'b0101, 4'b1111, 0};
        vecs[6]  = '{4'b1110, 4'b0011, 1};
        vecs[7]  = '{4'b1111, 4'b0001, 0};
        vecs[8]  = '{4'b1000, 4'b1111, 3};
        vecs[9]  = '{4'b0000, 4'b1111, -1};
        vecs[10] = '{4'b1111, 4'b0100, 2};
        vecs[11] = '{4'b1111, 4'b1111, 3};

        // Reset values
        areset = 1'b1;
        model_reset();
        repeat (2) @(posedge aclk);
        #1;
        check_reset_values("reset");
        areset = 1'b0;

        // Arbitration table: single-beat packets, sources drop valid after their handshake
        for (int v = 0; v < 12; v++) begin
            en_mask = vecs[v].en;
            src_act = vecs[v].vld;
            oneshot_all = 1;
            drive_sources();
            got = -1;
            rdy_seen = 0;
            for (int c = 0; c < 8; c++) begin
                step();
                if (|cap_s_ready) rdy_seen = 1;
                if (cap_m_hs) begin
                    got = int'(cap_m_tid);
                    break;
                end
            end
            chk($sformatf("vec%0d_tid", v), got, vecs[v].exp_tid);
            if (vecs[v].exp_tid < 0) chk($sformatf("vec%0d_no_ready", v), rdy_seen, 1'b0);
            src_act = 4'b0000;
            oneshot_all = 0;
            drive_sources();
            repeat (2) step();
        end

        // Fairness: all valid, 3-beat packets
        do_reset();
        for (int i = 0; i < NS; i++) src_len[i] = 3;
        src_act = 4'b1111;
        drive_sources();
        for (int c = 0; c < 200 && pkt_q.size() < 8; c++) step();
        chk("fair_pkts", pkt_q.size(), 8);
        chk("fair_pkt_count", pkt_count, 4'd8);
        for (int k = 0; k < 8 && k < pkt_q.size(); k++) chk($sformatf("fair_order%0d", k), pkt_q[k], k % 4);
        f = 0;
        while (f < tv_hist.size() && !tv_hist[f]) f++;
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            if (f + k >= tv_hist.size() || tv_hist[f + k] != (k % 4 != 3)) bad++;
        end
        chk("fair_beat_gap_pattern", bad, 0);

        // Mask: only 0 and 2, then drop 2 during its packet
        do_reset();
        for (int i = 0; i < NS; i++) src_len[i] = 3;
        en_mask = 4'b0101;
        src_act = 4'b1111;
        drive_sources();
        masked = 0;
        for (int c = 0; c < 300 && pkt_q.size() < 8; c++) begin
            step();
            if (!masked && cap_s_first[2] && pkt_q.size() >= 4) begin
                en_mask = 4'b0001;
                masked = 1;
            end
        end
        chk("mask_pkts", pkt_q.size(), 8);
        chk("mask_applied", masked, 1'b1);
        for (int k = 0; k < 8 && k < pkt_q.size(); k++)
            chk($sformatf("mask_order%0d", k), pkt_q[k], (k < 6) ? ((k % 2) * 2) : 0);

        // Backpressure: random master ready, 9-beat packets
        do_reset();
        for (int i = 0; i < NS; i++) src_len[i] = 9;
        src_act = 4'b1111;
        rand_ready = 1;
        drive_sources();
        for (int c = 0; c < 2000 && pkt_q.size() < 8; c++) step();
        chk("bp_pkts", pkt_q.size(), 8);
        for (int k = 0; k < 8 && k < pkt_q.size(); k++) chk($sformatf("bp_order%0d", k), pkt_q[k], k % 4);

        // Stalling source 1 while source 3 waits
        do_reset();
        for (int i = 0; i < NS; i++) src_len[i] = 5;
        src_act = 4'b1010;
        stall_en = 1;
        drive_sources();
        bad = 0;
        for (int c = 0; c < 100 && pkt_q.size() < 2; c++) begin
            step();
            if (pkt_q.size() == 0 && cap_s_ready[3]) bad++;
        end
        chk("stall_pkts", pkt_q.size(), 2);
        chk("stall_pause_cycles", pause_cycles, 5);
        chk("stall_no_early_grant3", bad, 0);
        if (pkt_q.size() >= 2) begin
            chk("stall_first_tid", pkt_q[0], 1);
            chk("stall_second_tid", pkt_q[1], 3);
        end else begin
            chk("stall_order_present", pkt_q.size(), 2);
        end

        // Single-beat packets and counter wrap
        do_reset();
        src_act = 4'b1111;
        drive_sources();
        for (int c = 0; c < 200 && pkt_q.size() < 20; c++) step();
        chk("wrap_pkts", pkt_q.size(), 20);
        chk("wrap_pkt_count", pkt_count, 4'd4);
        chk("wrap_all_tlast", nolast_cnt, 0);

        // Reset in the middle of a 9-beat packet from source 2
        do_reset();
        for (int i = 0; i < NS; i++) src_len[i] = 9;
        src_act = 4'b0100;
        drive_sources();
        got = 0;
        for (int c = 0; c < 50; c++) begin
            step();
            if (cap_s_hs[2] && cap_beat[2] == 3) begin
                got = 1;
                break;
            end
        end
        chk("midrst_reached_beat4", got, 1);
        chk("midrst_busy_before", busy, 1'b1);
        areset = 1'b1;
        #1;
        check_reset_values("midrst");
        model_reset();
        @(posedge aclk);
        #1;
        areset = 1'b0;
        src_act = 4'b1111;
        oneshot_all = 1;
        drive_sources();
        got = -1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (cap_m_hs) begin
                got = int'(cap_m_tid);
                break;
            end
        end
        chk("midrst_first_grant", got, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
